// File: rtl/uart_pkg.sv
// Shared UART definitions: RX sequencer states and baud constants.
// Used by the RX control path and the baud counter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE,
        ABORT
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int BAUD_1BIT      = 10416;
    localparam int BAUD_1P5BIT    = 15624;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side bundle of the UART receiver: received byte plus
// the status pulses/levels that go with it.
interface uart_rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int W = UART_DATA_BITS
);

    logic [W-1:0] rx_data;
    logic         rx_data_valid;
    logic         rx_frame_err;
    logic         rx_busy;

    modport master (
        output rx_data,
        output rx_data_valid,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_data_valid,
        input rx_frame_err,
        input rx_busy
    );

endinterface

// File: rtl/uart_rx_ctrl_sync.sv
// Serial-line synchronizer with falling-edge detect.
// Flops reset high so an idle line never shows a false edge.
module rx_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rx_arst_n,
    input  logic din,
    output logic line,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev;

    // Shift the pin through the synchronizer and remember the last synced value
    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n) begin
            sync_q <= '1;
            prev   <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev   <= sync_q[STAGES-1];
        end
    end

    assign line = sync_q[STAGES-1];
    assign fall = prev & ~line;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: start-bit qualification, 8N1 byte assembly,
// stop-bit check and baud counter control.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int START_FILTER = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic           clk,
    input  logic           rx_arst_n,
    input  logic           rx_en,
    input  logic           rx_serial_in,
    input  logic           baud_to_fsm,
    output logic           fsm_enable_baud,
    output logic           rx_rst,
    uart_rx_ctrl_if.master rx_if
);

    localparam int FW = $clog2(START_FILTER) + 1;

    rx_state_t            state;
    rx_state_t            nxt;
    logic                 line;
    logic                 fall;
    logic [FW-1:0]        filt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 filt_done;
    logic                 last_bit;
    logic                 sample;

    rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rx_arst_n (rx_arst_n),
        .din       (rx_serial_in),
        .line      (line),
        .fall      (fall)
    );

    assign filt_done = (filt == FW'(START_FILTER - 1));
    assign last_bit  = (bit_idx == 4'(DATA_BITS - 1));
    assign sample    = rx_en & baud_to_fsm;

    // Next-state decode; a dropped enable beats any tick
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (fall && rx_en) nxt = START;
            end
            START: begin
                if (!rx_en || line)  nxt = ABORT;
                else if (filt_done) nxt = DATA;
            end
            DATA: begin
                if (!rx_en)                      nxt = ABORT;
                else if (baud_to_fsm && last_bit) nxt = STOP;
            end
            STOP: begin
                if (!rx_en)           nxt = ABORT;
                else if (baud_to_fsm) nxt = DONE;
            end
            DONE: begin
                if (!rx_en)   nxt = ABORT;
                else if (line) nxt = IDLE;
            end
            ABORT: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State, registered outputs, filter/bit counters and shift register
    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n) begin
            state               <= IDLE;
            fsm_enable_baud     <= 1'b0;
            rx_rst              <= 1'b1;
            filt                <= '0;
            bit_idx             <= '0;
            shift               <= '0;
            rx_if.rx_data       <= '0;
            rx_if.rx_data_valid <= 1'b0;
            rx_if.rx_frame_err  <= 1'b0;
            rx_if.rx_busy       <= 1'b0;
        end else begin
            state               <= nxt;
            fsm_enable_baud     <= (nxt == START) || (nxt == DATA) ||
                                   (nxt == STOP);
            rx_rst              <= !((nxt == START) || (nxt == DATA) ||
                                     (nxt == STOP));
            rx_if.rx_busy       <= (nxt != IDLE);
            rx_if.rx_data_valid <= 1'b0;
            rx_if.rx_frame_err  <= 1'b0;

            if (state == START) filt <= filt + FW'(1);
            else                filt <= '0;

            if (state == START && nxt == DATA) bit_idx <= '0;

            if (state == DATA && sample) begin
                shift   <= {line, shift[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 4'd1;
            end

            if (state == STOP && sample) begin
                if (line) begin
                    rx_if.rx_data       <= shift;
                    rx_if.rx_data_valid <= 1'b1;
                end else begin
                    rx_if.rx_frame_err  <= 1'b1;
                end
            end
        end
    end

endmodule
